// File: rtl/data_mem_ctrl.sv
// Data-memory responder for the multicycle core.
// Owns a DEPTH x 32-bit word RAM and serves byte/half/word loads and stores
// selected by func3. Every access, good or rejected, ends with a one-cycle
// memReady pulse; rejected accesses also pulse memErr and leave RAM and
// readData untouched.
module data_mem_ctrl #(
  parameter int DEPTH        = 1024,
  parameter int READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rstN,
  input  logic        dMemRead,
  input  logic        dMemWrite,
  input  logic [2:0]  func3,
  input  logic [31:0] addr,
  input  logic [31:0] writeData,
  output logic [31:0] readData,
  output logic        memReady,
  output logic        memErr,
  output logic        busy
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] LAT_INIT = 4'(READ_LATENCY - 1);

  typedef enum logic [1:0] {IDLE, RD_WAIT, WRITE, RESP} state_t;

  state_t        state;
  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wordIdx;
  logic [1:0]    byteLo;
  logic [2:0]    f3Lat;
  logic [31:0]   wdLat;
  logic [3:0]    waitCnt;
  logic          reqErr;
  logic          reqSeen;

  // Request legality: strobe conflict, func3 legality per direction, alignment, range.
  function automatic logic accessErr(input logic rd, input logic wr,
                                     input logic [2:0] f3, input logic [31:0] a);
    logic e;
    if (rd && wr)
      e = 1'b1;
    else if (rd)
      e = !(f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    else
      e = !(f3 inside {3'b000, 3'b001, 3'b010});
    if (f3[1:0] == 2'b01 && a[0])
      e = 1'b1;
    if (f3[1:0] == 2'b10 && a[1:0] != 2'b00)
      e = 1'b1;
    if ({2'b00, a[31:2]} >= 32'(DEPTH))
      e = 1'b1;
    return e;
  endfunction

  // Pick the addressed byte/half out of the word and sign- or zero-extend it.
  function automatic logic [31:0] extendLoad(input logic [2:0] f3,
                                             input logic [31:0] word,
                                             input logic [1:0] lo);
    logic        [7:0]  b;
    logic        [15:0] h;
    logic signed [31:0] s;
    b = word[8*lo +: 8];
    h = word[16*lo[1] +: 16];
    case (f3)
      3'b000:  s = 32'(signed'(b));
      3'b001:  s = 32'(signed'(h));
      3'b100:  s = signed'({24'd0, b});
      3'b101:  s = signed'({16'd0, h});
      default: s = signed'(word);
    endcase
    return unsigned'(s);
  endfunction

  // Byte lanes touched by a store.
  function automatic logic [3:0] byteEnable(input logic [2:0] f3, input logic [1:0] lo);
    case (f3[1:0])
      2'b00:   byteEnable = 4'b0001 << lo;
      2'b01:   byteEnable = lo[1] ? 4'b1100 : 4'b0011;
      default: byteEnable = 4'b1111;
    endcase
  endfunction

  // Store data replicated so the low byte/half lands on every candidate lane.
  function automatic logic [31:0] laneData(input logic [2:0] f3, input logic [31:0] wd);
    case (f3[1:0])
      2'b00:   laneData = {4{wd[7:0]}};
      2'b01:   laneData = {2{wd[15:0]}};
      default: laneData = wd;
    endcase
  endfunction

  assign reqSeen = dMemRead || dMemWrite;
  assign reqErr  = accessErr(dMemRead, dMemWrite, func3, addr);
  assign busy    = (state != IDLE);

  // Capture the request operands on the accept edge; data path is not reset.
  always_ff @(posedge clk) begin
    if (state == IDLE && reqSeen) begin
      wordIdx <= addr[AW+1:2];
      byteLo  <= addr[1:0];
      f3Lat   <= func3;
      wdLat   <= writeData;
    end
  end

  // Access sequencer with registered response outputs.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state    <= IDLE;
      readData <= 32'd0;
      memReady <= 1'b0;
      memErr   <= 1'b0;
      waitCnt  <= 4'd0;
    end else begin
      memReady <= 1'b0;
      memErr   <= 1'b0;
      case (state)
        IDLE: begin
          if (reqSeen) begin
            if (reqErr) begin
              state    <= RESP;
              memReady <= 1'b1;
              memErr   <= 1'b1;
            end else if (dMemRead) begin
              state   <= RD_WAIT;
              waitCnt <= LAT_INIT;
            end else begin
              state <= WRITE;
            end
          end
        end
        RD_WAIT: begin
          if (waitCnt == 4'd0) begin
            readData <= extendLoad(f3Lat, mem[wordIdx], byteLo);
            memReady <= 1'b1;
            state    <= RESP;
          end else begin
            waitCnt <= waitCnt - 4'd1;
          end
        end
        WRITE: begin
          memReady <= 1'b1;
          state    <= RESP;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Byte-enable RAM write; reset forces IDLE so an abandoned store never commits.
  always_ff @(posedge clk) begin
    if (state == WRITE) begin
      for (int i = 0; i < 4; i++) begin
        if (byteEnable(f3Lat, byteLo)[i])
          mem[wordIdx][8*i +: 8] <= laneData(f3Lat, wdLat)[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: two instances (read latency 1 and 4) sharing the
// operand bus, each with its own strobes and reset, checked against a
// word-array model of the RAM and the load/store rules.
module tb_data_mem_ctrl;

  localparam int DEPTH = 1024;

  logic        clk;
  logic        rstN1, rstN4;
  logic        rd1, wr1, rd4, wr4;
  logic [2:0]  func3;
  logic [31:0] addr, writeData;
  logic [31:0] readData1, readData4;
  logic        memReady1, memReady4, memErr1, memErr4, busy1, busy4;

  int ntests = 0;
  int nfail  = 0;

  logic [31:0] mdl [2][DEPTH];
  logic [31:0] expRd [2];

  data_mem_ctrl #(.DEPTH(DEPTH), .READ_LATENCY(1)) dut1 (
    .clk(clk), .rstN(rstN1), .dMemRead(rd1), .dMemWrite(wr1), .func3(func3),
    .addr(addr), .writeData(writeData), .readData(readData1),
    .memReady(memReady1), .memErr(memErr1), .busy(busy1));

  data_mem_ctrl #(.DEPTH(DEPTH), .READ_LATENCY(4)) dut4 (
    .clk(clk), .rstN(rstN4), .dMemRead(rd4), .dMemWrite(wr4), .func3(func3),
    .addr(addr), .writeData(writeData), .readData(readData4),
    .memReady(memReady4), .memErr(memErr4), .busy(busy4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic logic obsRdy(input int s);
    return (s != 0) ? memReady4 : memReady1;
  endfunction
  function automatic logic obsErr(input int s);
    return (s != 0) ? memErr4 : memErr1;
  endfunction
  function automatic logic obsBusy(input int s);
    return (s != 0) ? busy4 : busy1;
  endfunction
  function automatic logic [31:0] obsRd(input int s);
    return (s != 0) ? readData4 : readData1;
  endfunction

  // One complete access on instance s with full response checking.
  task automatic access(input int s, input bit rd, input bit wr,
                        input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    int          size, lat, cyc;
    bit          legal, err;
    int          idx, sh;
    logic [31:0] mask, v;
    size  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    legal = (rd && wr) ? 1'b0 : rd ? (f3 inside {0, 1, 2, 4, 5}) : (f3 inside {0, 1, 2});
    err   = !legal || (a % size != 0) || (a / 4 >= DEPTH);
    idx   = int'(a / 4);
    sh    = 8 * int'(a % 4);
    if (!err && wr) begin
      mask = (size == 4) ? 32'hFFFF_FFFF : (((32'd1 << (8 * size)) - 32'd1) << sh);
      mdl[s][idx] = (mdl[s][idx] & ~mask) | ((wd << sh) & mask);
    end
    if (!err && rd) begin
      v = mdl[s][idx] >> sh;
      if (size == 1) begin
        v = v & 32'hFF;
        if (f3 == 3'b000 && v >= 32'd128) v = v | 32'hFFFF_FF00;
      end else if (size == 2) begin
        v = v & 32'hFFFF;
        if (f3 == 3'b001 && v >= 32'd32768) v = v | 32'hFFFF_0000;
      end
      expRd[s] = v;
    end
    lat = err ? 1 : wr ? 2 : ((s != 0) ? 5 : 2);

    @(negedge clk);
    func3 = f3; addr = a; writeData = wd;
    if (s != 0) begin rd4 = rd; wr4 = wr; end
    else        begin rd1 = rd; wr1 = wr; end
    @(posedge clk); #1;
    rd1 = 1'b0; wr1 = 1'b0; rd4 = 1'b0; wr4 = 1'b0;
    cyc = 1;
    while (!obsRdy(s) && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    ntests++;
    if (cyc != lat) begin
      nfail++;
      $display("FAIL latency s=%0d f3=%0d a=%h rd=%0b wr=%0b: got %0d cycles, expected %0d",
               s, f3, a, rd, wr, cyc, lat);
    end
    ntests++;
    if (obsErr(s) !== err) begin
      nfail++;
      $display("FAIL memErr s=%0d f3=%0d a=%h: got %b, expected %b", s, f3, a, obsErr(s), err);
    end
    ntests++;
    if (obsRd(s) !== expRd[s]) begin
      nfail++;
      $display("FAIL readData s=%0d f3=%0d a=%h: got %h, expected %h", s, f3, a, obsRd(s), expRd[s]);
    end
    @(posedge clk); #1;
    ntests++;
    if (obsRdy(s) !== 1'b0 || obsErr(s) !== 1'b0 || obsBusy(s) !== 1'b0) begin
      nfail++;
      $display("FAIL pulse_end s=%0d: memReady=%b memErr=%b busy=%b, expected 0 0 0",
               s, obsRdy(s), obsErr(s), obsBusy(s));
    end
  endtask

  task automatic test_reset;
    rstN1 = 1'b0; rstN4 = 1'b0;
    rd1 = 1'b0; wr1 = 1'b0; rd4 = 1'b0; wr4 = 1'b0;
    func3 = 3'd0; addr = 32'd0; writeData = 32'd0;
    expRd[0] = 32'd0; expRd[1] = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      ntests++;
      if (obsRd(s) !== 32'd0 || obsRdy(s) !== 1'b0 || obsErr(s) !== 1'b0 || obsBusy(s) !== 1'b0) begin
        nfail++;
        $display("FAIL reset_state s=%0d: readData=%h memReady=%b memErr=%b busy=%b, expected all 0",
                 s, obsRd(s), obsRdy(s), obsErr(s), obsBusy(s));
      end
    end
    @(negedge clk);
    rstN1 = 1'b1; rstN4 = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed;
    access(0, 0, 1, 3'b010, 32'h10, 32'hDEADBEEF);
    access(0, 1, 0, 3'b010, 32'h10, 32'h0);
    ntests++;
    if (readData1 !== 32'hDEADBEEF) begin
      nfail++; $display("FAIL lw_literal: got %h, expected deadbeef", readData1);
    end
    access(0, 0, 1, 3'b000, 32'h11, 32'h000000A5);
    access(0, 1, 0, 3'b010, 32'h10, 32'h0);
    ntests++;
    if (readData1 !== 32'hDEADA5EF) begin
      nfail++; $display("FAIL sb_merge: got %h, expected deada5ef", readData1);
    end
    access(0, 1, 0, 3'b000, 32'h11, 32'h0);
    ntests++;
    if (readData1 !== 32'hFFFFFFA5) begin
      nfail++; $display("FAIL lb_sign: got %h, expected ffffffa5", readData1);
    end
    access(0, 1, 0, 3'b100, 32'h11, 32'h0);
    ntests++;
    if (readData1 !== 32'h000000A5) begin
      nfail++; $display("FAIL lbu_zero: got %h, expected 000000a5", readData1);
    end
    access(0, 0, 1, 3'b001, 32'h12, 32'h00008001);
    access(0, 1, 0, 3'b001, 32'h12, 32'h0);
    ntests++;
    if (readData1 !== 32'hFFFF8001) begin
      nfail++; $display("FAIL lh_sign: got %h, expected ffff8001", readData1);
    end
    access(0, 1, 0, 3'b101, 32'h12, 32'h0);
    ntests++;
    if (readData1 !== 32'h00008001) begin
      nfail++; $display("FAIL lhu_zero: got %h, expected 00008001", readData1);
    end
  endtask

  task automatic test_errors;
    access(0, 1, 0, 3'b010, 32'h13, 32'h0);
    access(0, 0, 1, 3'b001, 32'h11, 32'h1234);
    access(0, 1, 0, 3'b010, 32'(4 * DEPTH), 32'h0);
    access(0, 0, 1, 3'b010, 32'(4 * DEPTH), 32'h55);
    access(0, 1, 1, 3'b010, 32'h10, 32'h11111111);
    access(0, 1, 0, 3'b011, 32'h10, 32'h0);
    access(0, 0, 1, 3'b100, 32'h10, 32'h22);
    access(0, 1, 0, 3'b010, 32'h10, 32'h0);
    ntests++;
    if (readData1 !== 32'h8001A5EF) begin
      nfail++; $display("FAIL ram_after_errors: got %h, expected 8001a5ef", readData1);
    end
  endtask

  task automatic test_held_request;
    int pulses;
    pulses = 0;
    @(negedge clk);
    func3 = 3'b010; addr = 32'h30; writeData = 32'hCAFEF00D; wr1 = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (memReady1) pulses++;
      if (i == 0) wr1 = 1'b0;
    end
    mdl[0][12] = 32'hCAFEF00D;
    ntests++;
    if (pulses != 1) begin
      nfail++; $display("FAIL held_request: got %0d memReady pulses, expected 1", pulses);
    end
    access(0, 1, 0, 3'b010, 32'h30, 32'h0);
  endtask

  task automatic test_random;
    logic [31:0] a;
    int          r;
    for (int w = 0; w < 16; w++)
      access(0, 0, 1, 3'b010, 32'(4 * w), $urandom);
    for (int n = 0; n < 200; n++) begin
      a = 32'($urandom_range(0, 63));
      if ($urandom_range(0, 9) == 0) a = 32'(4 * DEPTH) + 32'($urandom_range(0, 255));
      r = $urandom_range(0, 9);
      access(0, r == 0 || (r >= 1 && r <= 5), r == 0 || r >= 6,
             3'($urandom_range(0, 7)), a, $urandom);
    end
  endtask

  task automatic test_reset_midread;
    int pulses;
    access(1, 0, 1, 3'b010, 32'h20, 32'h12345678);
    access(1, 1, 0, 3'b010, 32'h20, 32'h0);
    @(negedge clk);
    func3 = 3'b010; addr = 32'h20; rd4 = 1'b1;
    @(posedge clk); #1;
    rd4 = 1'b0;
    @(posedge clk); #1;
    rstN4 = 1'b0;
    #1;
    expRd[1] = 32'd0;
    ntests++;
    if (busy4 !== 1'b0 || memReady4 !== 1'b0 || readData4 !== 32'd0) begin
      nfail++;
      $display("FAIL reset_midread: busy=%b memReady=%b readData=%h, expected 0 0 0",
               busy4, memReady4, readData4);
    end
    @(negedge clk);
    rstN4 = 1'b1;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (memReady4) pulses++;
    end
    ntests++;
    if (pulses != 0) begin
      nfail++; $display("FAIL no_pulse_after_reset: got %0d pulses, expected 0", pulses);
    end
    access(1, 1, 0, 3'b010, 32'h20, 32'h0);
    access(1, 1, 0, 3'b000, 32'h23, 32'h0);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_errors();
    test_held_request();
    test_random();
    test_reset_midread();
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
